// File: rtl/switch_demux.sv
// switch_demux: one 4-bit input stream steered into two independently
// drained holding registers. The route comes from CE (manual) or from an
// internal toggle flag (AUTO=1) that flips on every accept made in auto mode.
// Each route keeps a wrapping count of delivered nibbles.
module switch_demux (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       AUTO,
  input  logic [3:0] IN,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic [3:0] OUT_1,
  output logic       OUT_1_VALID,
  input  logic       OUT_1_READY,
  output logic [3:0] OUT_2,
  output logic       OUT_2_VALID,
  input  logic       OUT_2_READY,
  output logic       SEL,
  output logic [3:0] CNT_1,
  output logic [3:0] CNT_2
);

  // Route holding registers, valid flags, delivery counters, toggle flag
  logic [3:0] data1_p1;
  logic [3:0] data2_p1;
  logic       vld1_p1;
  logic       vld2_p1;
  logic [3:0] cnt1_p1;
  logic [3:0] cnt2_p1;
  logic       tgl_p1;

  // Combinational steering and handshake terms
  logic       sel;
  logic       tgt_vld;
  logic       tgt_rdy;
  logic       accept;
  logic       load1;
  logic       load2;
  logic       dlv1;
  logic       dlv2;

  // Counters wrap naturally modulo 16.
  function automatic logic [3:0] wrap_inc(input logic [3:0] c, input logic en);
    logic [3:0] r;
    r = en ? (c + 4'd1) : c;
    return r;
  endfunction

  // Route selection and ready: IN_READY depends only on state, SEL and the
  // sink readies, never on IN_VALID, so no IN_VALID -> IN_READY path exists.
  always_comb begin
    sel      = AUTO ? tgl_p1 : CE;
    tgt_vld  = sel ? vld2_p1 : vld1_p1;
    tgt_rdy  = sel ? OUT_2_READY : OUT_1_READY;
    IN_READY = !RST & (!tgt_vld | tgt_rdy);
    accept   = IN_VALID & IN_READY;
    load1    = accept & !sel;
    load2    = accept & sel;
    dlv1     = vld1_p1 & OUT_1_READY;
    dlv2     = vld2_p1 & OUT_2_READY;
  end

  // ---- stage p1: route 1 register; a load in the delivery cycle keeps valid set
  always_ff @(posedge CLK) begin
    if (RST) begin
      data1_p1 <= 4'd0;
      vld1_p1  <= 1'b0;
      cnt1_p1  <= 4'd0;
    end else begin
      if (load1) data1_p1 <= IN;
      vld1_p1 <= load1 | (vld1_p1 & !OUT_1_READY);
      cnt1_p1 <= wrap_inc(cnt1_p1, dlv1);
    end
  end

  // Route 2 register, mirror of route 1
  always_ff @(posedge CLK) begin
    if (RST) begin
      data2_p1 <= 4'd0;
      vld2_p1  <= 1'b0;
      cnt2_p1  <= 4'd0;
    end else begin
      if (load2) data2_p1 <= IN;
      vld2_p1 <= load2 | (vld2_p1 & !OUT_2_READY);
      cnt2_p1 <= wrap_inc(cnt2_p1, dlv2);
    end
  end

  // Toggle flag flips only on auto-mode accepts; held while AUTO=0
  always_ff @(posedge CLK) begin
    if (RST) begin
      tgl_p1 <= 1'b0;
    end else if (accept & AUTO) begin
      tgl_p1 <= !tgl_p1;
    end
  end

  // Output mapping
  always_comb begin
    SEL         = sel;
    OUT_1       = data1_p1;
    OUT_1_VALID = vld1_p1;
    OUT_2       = data2_p1;
    OUT_2_VALID = vld2_p1;
    CNT_1       = cnt1_p1;
    CNT_2       = cnt2_p1;
  end

endmodule

// File: tb/tb_switch_demux.sv
// Directed bench for switch_demux with a per-route scoreboard: stimulus
// pushes each nibble expected on a route; a monitor pops and compares it
// whenever that route delivers.
module tb_switch_demux;
  logic       CLK = 1'b0;
  logic       RST;
  logic       CE;
  logic       AUTO;
  logic [3:0] IN;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] OUT_1;
  logic       OUT_1_VALID;
  logic       OUT_1_READY;
  logic [3:0] OUT_2;
  logic       OUT_2_VALID;
  logic       OUT_2_READY;
  logic       SEL;
  logic [3:0] CNT_1;
  logic [3:0] CNT_2;

  int errors = 0;
  int checks = 0;
  logic [3:0] q1[$];
  logic [3:0] q2[$];

  switch_demux dut (
    .CLK(CLK), .RST(RST), .CE(CE), .AUTO(AUTO),
    .IN(IN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_1(OUT_1), .OUT_1_VALID(OUT_1_VALID), .OUT_1_READY(OUT_1_READY),
    .OUT_2(OUT_2), .OUT_2_VALID(OUT_2_VALID), .OUT_2_READY(OUT_2_READY),
    .SEL(SEL), .CNT_1(CNT_1), .CNT_2(CNT_2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic ce,
                       input logic au, input logic r1, input logic r2);
    IN_VALID    = v;
    IN          = d;
    CE          = ce;
    AUTO        = au;
    OUT_1_READY = r1;
    OUT_2_READY = r2;
  endtask

  // Monitor: a delivery happens at the coming edge when valid & ready
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (OUT_1_VALID && OUT_1_READY) begin
        if (q1.size() == 0) chk("out1_unexpected", 1, 0);
        else chk("out1_data", int'(OUT_1), int'(q1.pop_front()));
      end
      if (OUT_2_VALID && OUT_2_READY) begin
        if (q2.size() == 0) chk("out2_unexpected", 1, 0);
        else chk("out2_data", int'(OUT_2), int'(q2.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic sel_exp [4];
    sel_exp = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset with a valid nibble pending: nothing may load
    RST = 1'b1;
    drive(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("rst_in_ready_c1", int'(IN_READY), 0);
    next_cycle();
    sample();
    chk("rst_in_ready_c2", int'(IN_READY), 0);
    chk("rst_out1", int'(OUT_1), 0);
    chk("rst_out1_valid", int'(OUT_1_VALID), 0);
    chk("rst_out2", int'(OUT_2), 0);
    chk("rst_out2_valid", int'(OUT_2_VALID), 0);
    chk("rst_cnt1", int'(CNT_1), 0);
    chk("rst_cnt2", int'(CNT_2), 0);
    chk("rst_sel", int'(SEL), 0);

    // Manual route to OUT_1, sink not ready: value held
    next_cycle();
    RST = 1'b0;
    drive(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    q1.push_back(4'hA);
    sample();
    chk("man_in_ready", int'(IN_READY), 1);
    chk("man_sel", int'(SEL), 0);
    next_cycle();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("man_out1", int'(OUT_1), 'hA);
    chk("man_out1_valid", int'(OUT_1_VALID), 1);
    chk("man_out2_valid", int'(OUT_2_VALID), 0);
    chk("man_cnt1", int'(CNT_1), 0);
    next_cycle();
    sample();
    chk("man_out1_hold", int'(OUT_1), 'hA);

    // Backpressure: route 1 full and not ready
    next_cycle();
    drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("bp_in_ready_blocked", int'(IN_READY), 0);
    chk("bp_out1_hold", int'(OUT_1), 'hA);
    next_cycle();
    sample();
    chk("bp_out1_hold2", int'(OUT_1), 'hA);
    chk("bp_cnt1_hold", int'(CNT_1), 0);
    next_cycle();
    drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
    q1.push_back(4'h5);
    sample();
    chk("bp_in_ready_open", int'(IN_READY), 1);
    next_cycle();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("bp_out1", int'(OUT_1), 5);
    chk("bp_out1_valid", int'(OUT_1_VALID), 1);
    chk("bp_cnt1", int'(CNT_1), 1);
    next_cycle();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("bp_cnt1_drained", int'(CNT_1), 2);
    chk("bp_out1_valid_clr", int'(OUT_1_VALID), 0);

    // Fresh start for the auto scenario
    next_cycle();
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;

    // Auto alternate: 1,2,3,4 back-to-back, both sinks ready
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i + 1), 1'b0, 1'b1, 1'b1, 1'b1);
      if (sel_exp[i]) q2.push_back(4'(i + 1));
      else q1.push_back(4'(i + 1));
      sample();
      chk("auto_sel", int'(SEL), int'(sel_exp[i]));
      chk("auto_in_ready", int'(IN_READY), 1);
      next_cycle();
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    next_cycle();
    sample();
    chk("auto_cnt1", int'(CNT_1), 2);
    chk("auto_cnt2", int'(CNT_2), 2);
    chk("auto_out1_last", int'(OUT_1), 3);
    chk("auto_out2_last", int'(OUT_2), 4);
    chk("auto_sel_after", int'(SEL), 0);

    // Counter wrap: 14 more route-2 deliveries on top of 2 -> 16 total
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      drive(1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      q2.push_back(4'(i));
    end
    next_cycle();
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    sample();
    chk("wrap_cnt2_15", int'(CNT_2), 15);
    next_cycle();
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    chk("wrap_cnt2_0", int'(CNT_2), 0);
    chk("wrap_cnt1_same", int'(CNT_1), 2);

    // Fill both routes (TGL ends at 1), CE changes in the accept cycle
    next_cycle();
    drive(1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
    q1.push_back(4'h7);
    sample();
    chk("mid_sel_auto", int'(SEL), 0);
    next_cycle();
    drive(1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0);
    q2.push_back(4'h8);
    sample();
    chk("mid_sel_ce", int'(SEL), 1);
    chk("mid_in_ready", int'(IN_READY), 1);
    next_cycle();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    chk("mid_out1", int'(OUT_1), 7);
    chk("mid_out2", int'(OUT_2), 8);
    chk("mid_v1", int'(OUT_1_VALID), 1);
    chk("mid_v2", int'(OUT_2_VALID), 1);
    chk("mid_tgl_held", int'(SEL), 1);
    chk("mid_full_in_ready", int'(IN_READY), 0);

    // Reset mid-operation, sinks ready: undelivered nibbles discarded
    next_cycle();
    RST = 1'b1;
    drive(1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1);
    q1.delete();
    q2.delete();
    sample();
    chk("mid_rst_in_ready", int'(IN_READY), 0);
    next_cycle();
    RST = 1'b0;
    drive(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0);
    q1.push_back(4'h9);
    sample();
    chk("post_rst_v1", int'(OUT_1_VALID), 0);
    chk("post_rst_v2", int'(OUT_2_VALID), 0);
    chk("post_rst_cnt1", int'(CNT_1), 0);
    chk("post_rst_cnt2", int'(CNT_2), 0);
    chk("post_rst_out1", int'(OUT_1), 0);
    chk("post_rst_tgl", int'(SEL), 0);
    chk("post_rst_in_ready", int'(IN_READY), 1);
    next_cycle();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    chk("post_rst_load1", int'(OUT_1), 9);
    chk("post_rst_load_v1", int'(OUT_1_VALID), 1);
    chk("post_rst_load_v2", int'(OUT_2_VALID), 0);
    chk("post_rst_tgl_flip", int'(SEL), 1);

    // TGL held across a manual interval
    next_cycle();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    chk("hold_sel_manual", int'(SEL), 0);
    next_cycle();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    chk("hold_sel_resume", int'(SEL), 1);
    chk("hold_cnt1", int'(CNT_1), 1);

    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
